// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: instruction classes, ALU ops,
// branch conditions and the shift-sequencing FSM states.
package exec_pkg;

   localparam logic [2:0] CLS_ALU    = 3'd0;
   localparam logic [2:0] CLS_BRANCH = 3'd1;
   localparam logic [2:0] CLS_JUMP   = 3'd2;
   localparam logic [2:0] CLS_LOAD   = 3'd3;
   localparam logic [2:0] CLS_STORE  = 3'd4;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/exec_shifter.sv
// Iterative shifter: consumes up to SHIFT_STEP bits of shift amount per cycle
// after i_start; o_done rises once the remaining amount reaches zero.
module exec_shifter
   import exec_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic [3:0]               i_op,
   input  logic [XLEN-1:0]          i_value,
   input  logic [$clog2(XLEN)-1:0]  i_shamt,
   output logic                     o_done,
   output logic [XLEN-1:0]          o_result
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

   logic [SHW-1:0]  r_rem;
   logic [3:0]      r_op;
   logic [XLEN-1:0] r_val;
   logic [SHW-1:0]  w_step;
   logic [XLEN-1:0] w_next;

   always_comb begin
      w_step = r_rem;
      if ({1'b0, r_rem} > STEP) w_step = STEP[SHW-1:0];
      case (r_op)
         ALU_SLL: w_next = r_val << w_step;
         ALU_SRA: w_next = $signed(r_val) >>> w_step;
         default: w_next = r_val >> w_step;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem <= '0;
         r_op  <= ALU_ADD;
      end else if (i_start) begin
         r_rem <= i_shamt;
         r_op  <= i_op;
      end else begin
         r_rem <= r_rem - w_step;
      end
   end

   // working value is pure datapath; it is reloaded on every start
   always_ff @(posedge clk) begin
      if (i_start) r_val <= i_value;
      else         r_val <= w_next;
   end

   assign o_done   = (r_rem == '0);
   assign o_result = r_val;

endmodule

// File: rtl/exec_unit_pipe.sv
// Execute stage: ALU, branch/jump resolution and load/store address generation
// feeding a one-entry output register with valid/ready backpressure.
module exec_unit_pipe
   import exec_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int PC_W       = 10,
   parameter int IMM_W      = 20,
   parameter int SHIFT_STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [3:0]        in_alu_op,
   input  logic [2:0]        in_funct3,
   input  logic [XLEN-1:0]   in_op0,
   input  logic [XLEN-1:0]   in_op1,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [4:0]        in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_class,
   output logic [2:0]        out_funct3,
   output logic [4:0]        out_rd,
   output logic [XLEN-1:0]   out_result,
   output logic              out_wb_en,
   output logic [XLEN-1:0]   out_mem_addr,
   output logic [XLEN-1:0]   out_store_data,
   output logic              redirect_valid,
   output logic [PC_W-1:0]   redirect_pc
);

   localparam int SHW = $clog2(XLEN);

   state_t          r_state, w_state_nxt;
   logic            w_out_free, w_accept, w_is_shift, w_sh_start;
   logic            w_nsh_load, w_sh_load, w_sh_done, w_taken, w_wb_en;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_alu, w_result, w_addr, w_sh_result;
   logic [PC_W-1:0] w_target, w_link;
   logic [4:0]      r_pend_rd;
   logic [2:0]      r_pend_f3;
   logic            r_pend_wb;
   logic [XLEN-1:0] r_pend_addr, r_pend_sdata;

   assign w_shamt    = in_op1[SHW-1:0];
   assign w_out_free = !out_valid || out_ready;
   assign in_ready   = rst_n && !flush && (r_state == ST_IDLE) && w_out_free;
   assign w_accept   = in_valid && in_ready;
   assign w_is_shift = (in_class == CLS_ALU) && is_shift_op(in_alu_op) && (w_shamt != '0);
   assign w_sh_start = w_accept && w_is_shift;
   assign w_nsh_load = w_accept && !w_is_shift;
   assign w_sh_load  = !flush && w_out_free &&
                       (((r_state == ST_SHIFT) && w_sh_done) || (r_state == ST_DONE));

   // shifts with a zero amount reach this path and simply pass op0 through
   always_comb begin
      w_alu = '0;
      case (in_alu_op)
         ALU_ADD:    w_alu = in_op0 + in_op1;
         ALU_SUB:    w_alu = in_op0 - in_op1;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:    w_alu = in_op0;
         ALU_SLT:    w_alu = {{(XLEN-1){1'b0}}, $signed(in_op0) < $signed(in_op1)};
         ALU_SLTU:   w_alu = {{(XLEN-1){1'b0}}, in_op0 < in_op1};
         ALU_XOR:    w_alu = in_op0 ^ in_op1;
         ALU_OR:     w_alu = in_op0 | in_op1;
         ALU_AND:    w_alu = in_op0 & in_op1;
         ALU_PASS_B: w_alu = in_op1;
         default:    w_alu = '0;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (in_funct3)
         F3_BEQ:  w_taken = (in_op0 == in_op1);
         F3_BNE:  w_taken = (in_op0 != in_op1);
         F3_BLT:  w_taken = ($signed(in_op0) < $signed(in_op1));
         F3_BGE:  w_taken = ($signed(in_op0) >= $signed(in_op1));
         F3_BLTU: w_taken = (in_op0 < in_op1);
         F3_BGEU: w_taken = (in_op0 >= in_op1);
         default: w_taken = 1'b0;
      endcase
      if (in_class == CLS_JUMP)        w_taken = 1'b1;
      else if (in_class != CLS_BRANCH) w_taken = 1'b0;
   end

   assign w_target = in_pc + in_imm[PC_W-1:0];
   assign w_link   = in_pc + PC_W'(1);
   assign w_addr   = in_op0 + {{(XLEN-12){in_imm[11]}}, in_imm[11:0]};
   assign w_wb_en  = ((in_class == CLS_ALU) || (in_class == CLS_JUMP) ||
                      (in_class == CLS_LOAD)) && (in_rd != 5'd0);
   assign w_result = (in_class == CLS_ALU)  ? w_alu :
                     (in_class == CLS_JUMP) ? {{(XLEN-PC_W){1'b0}}, w_link} : '0;

   exec_shifter #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_sh_start),
      .i_op     (in_alu_op),
      .i_value  (in_op0),
      .i_shamt  (w_shamt),
      .o_done   (w_sh_done),
      .o_result (w_sh_result)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_sh_start) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (flush) w_state_nxt = ST_IDLE;
                   else if (w_sh_done) w_state_nxt = w_out_free ? ST_IDLE : ST_DONE;
         ST_DONE:  if (flush || w_out_free) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // side fields of a shift instruction wait here while the shifter runs
   always_ff @(posedge clk) begin
      if (w_sh_start) begin
         r_pend_rd    <= in_rd;
         r_pend_f3    <= in_funct3;
         r_pend_wb    <= w_wb_en;
         r_pend_addr  <= w_addr;
         r_pend_sdata <= in_op1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         out_class      <= '0;
         out_funct3     <= '0;
         out_rd         <= '0;
         out_result     <= '0;
         out_wb_en      <= 1'b0;
         out_mem_addr   <= '0;
         out_store_data <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else if (flush) begin
         out_valid      <= 1'b0;
         redirect_valid <= 1'b0;
      end else if (w_nsh_load) begin
         out_valid      <= 1'b1;
         out_class      <= in_class;
         out_funct3     <= in_funct3;
         out_rd         <= in_rd;
         out_result     <= w_result;
         out_wb_en      <= w_wb_en;
         out_mem_addr   <= w_addr;
         out_store_data <= in_op1;
         redirect_valid <= w_taken;
         redirect_pc    <= w_target;
      end else if (w_sh_load) begin
         out_valid      <= 1'b1;
         out_class      <= CLS_ALU;
         out_funct3     <= r_pend_f3;
         out_rd         <= r_pend_rd;
         out_result     <= w_sh_result;
         out_wb_en      <= r_pend_wb;
         out_mem_addr   <= r_pend_addr;
         out_store_data <= r_pend_sdata;
         redirect_valid <= 1'b0;
      end else begin
         redirect_valid <= 1'b0;
         if (out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed bench for exec_unit_pipe with hand-computed expectations.
module tb_exec_unit_pipe;
   import exec_pkg::*;

   logic        clk, rst_n, flush;
   logic        in_valid, in_ready;
   logic [2:0]  in_class;
   logic [3:0]  in_alu_op;
   logic [2:0]  in_funct3;
   logic [31:0] in_op0, in_op1;
   logic [19:0] in_imm;
   logic [9:0]  in_pc;
   logic [4:0]  in_rd;
   logic        out_valid, out_ready;
   logic [2:0]  out_class, out_funct3;
   logic [4:0]  out_rd;
   logic [31:0] out_result, out_mem_addr, out_store_data;
   logic        out_wb_en, redirect_valid;
   logic [9:0]  redirect_pc;

   int n_total = 0;
   int n_bad   = 0;

   exec_unit_pipe #(.XLEN(32), .PC_W(10), .IMM_W(20), .SHIFT_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_alu_op(in_alu_op), .in_funct3(in_funct3),
      .in_op0(in_op0), .in_op1(in_op1), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_funct3(out_funct3), .out_rd(out_rd),
      .out_result(out_result), .out_wb_en(out_wb_en),
      .out_mem_addr(out_mem_addr), .out_store_data(out_store_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] c, input logic [3:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [19:0] imm,
                        input logic [9:0] pc, input logic [4:0] rd);
      in_valid = 1'b1; in_class = c; in_alu_op = op; in_funct3 = f3;
      in_op0 = a; in_op1 = b; in_imm = imm; in_pc = pc; in_rd = rd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  t_op  [9] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR,
                              ALU_OR, ALU_AND, ALU_PASS_B, 4'd11};
   logic [31:0] t_a   [9] = '{32'd10, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0,
                              32'hF0F0, 32'hF0F0, 32'h0, 32'h55};
   logic [31:0] t_b   [9] = '{32'd20, 32'd7, 32'd1, 32'd1, 32'hFF00,
                              32'hFF00, 32'hFF00, 32'h1234, 32'h66};
   logic [31:0] t_exp [9] = '{32'd30, 32'hFFFFFFFE, 32'd1, 32'd0, 32'h0FF0,
                              32'hFFF0, 32'hF000, 32'h1234, 32'h0};

   initial begin
      logic seen;
      rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_class = '0; in_alu_op = '0; in_funct3 = '0;
      in_op0 = '0; in_op1 = '0; in_imm = '0; in_pc = '0; in_rd = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_redirect", redirect_valid, 0);
      rst_n = 1'b1;
      #1 chk("post_rst_in_ready", in_ready, 1);

      // ALU ADD
      drive(CLS_ALU, ALU_ADD, 3'd0, 32'd5, 32'd7, 20'd0, 10'd0, 5'd3);
      step();
      chk("add_valid", out_valid, 1);
      chk("add_result", out_result, 12);
      chk("add_wb", out_wb_en, 1);
      chk("add_rd", out_rd, 3);
      chk("add_redir", redirect_valid, 0);

      // BLT taken, then BGE not taken with the same operands
      drive(CLS_BRANCH, ALU_ADD, F3_BLT, 32'hFFFFFFFF, 32'd1, 20'hFFFF8, 10'h010, 5'd0);
      step();
      chk("blt_redir", redirect_valid, 1);
      chk("blt_pc", redirect_pc, 10'h008);
      chk("blt_wb", out_wb_en, 0);
      drive(CLS_BRANCH, ALU_ADD, F3_BGE, 32'hFFFFFFFF, 32'd1, 20'hFFFF8, 10'h010, 5'd0);
      step();
      chk("bge_valid", out_valid, 1);
      chk("bge_redir", redirect_valid, 0);
      in_valid = 1'b0;
      step();
      chk("drain_valid", out_valid, 0);

      // SRA by 9 with 4 bits per cycle
      drive(CLS_ALU, ALU_SRA, 3'd0, 32'h80000000, 32'd9, 20'd0, 10'd0, 5'd5);
      step();
      in_valid = 1'b0;
      chk("sra_busy_ready", in_ready, 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("sra_valid_c%0d", k), out_valid, (k == 4));
      end
      chk("sra_result", out_result, 32'hFFC00000);
      chk("sra_rd", out_rd, 5);
      chk("sra_ready", in_ready, 1);
      step();

      // STORE held under backpressure
      out_ready = 1'b0;
      drive(CLS_STORE, ALU_ADD, 3'd2, 32'h100, 32'hAB, 20'h00FFC, 10'd0, 5'd7);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("st_hold_valid%0d", k), out_valid, 1);
         chk($sformatf("st_hold_addr%0d", k), out_mem_addr, 32'hFC);
         chk($sformatf("st_hold_data%0d", k), out_store_data, 32'hAB);
         chk($sformatf("st_hold_ready%0d", k), in_ready, 0);
         step();
      end
      chk("st_wb", out_wb_en, 0);

      // drain-and-accept, then a full-rate run of ALU ops
      out_ready = 1'b1;
      drive(CLS_ALU, ALU_ADD, 3'd0, 32'd1, 32'd2, 20'd0, 10'd0, 5'd4);
      #1 chk("b2b_ready", in_ready, 1);
      step();
      chk("b2b_first", out_result, 3);
      for (int i = 0; i < 9; i++) begin
         drive(CLS_ALU, t_op[i], 3'd0, t_a[i], t_b[i], 20'd0, 10'd0, 5'd4);
         step();
         chk($sformatf("alu_tab%0d", i), out_result, t_exp[i]);
      end

      // JUMP link and target
      drive(CLS_JUMP, ALU_ADD, 3'd0, 32'd0, 32'd0, 20'h00010, 10'h020, 5'd1);
      step();
      chk("jal_redir", redirect_valid, 1);
      chk("jal_pc", redirect_pc, 10'h030);
      chk("jal_link", out_result, 32'h21);
      chk("jal_wb", out_wb_en, 1);

      // LOAD to x0, zero-amount shift
      drive(CLS_LOAD, ALU_ADD, 3'd2, 32'h200, 32'd0, 20'h00008, 10'd0, 5'd0);
      step();
      chk("ld_addr", out_mem_addr, 32'h208);
      chk("ld_wb", out_wb_en, 0);
      chk("ld_redir", redirect_valid, 0);
      drive(CLS_ALU, ALU_SLL, 3'd0, 32'd5, 32'd32, 20'd0, 10'd0, 5'd2);
      step();
      in_valid = 1'b0;
      chk("sll0_valid", out_valid, 1);
      chk("sll0_result", out_result, 5);
      step();

      // flush during SHIFT
      drive(CLS_ALU, ALU_SRL, 3'd0, 32'hF0, 32'd8, 20'd0, 10'd0, 5'd6);
      step();
      in_valid = 1'b0;
      step();
      flush = 1'b1;
      #1 chk("fl_sh_ready", in_ready, 0);
      step();
      flush = 1'b0;
      #1;
      chk("fl_sh_valid", out_valid, 0);
      chk("fl_sh_ready_after", in_ready, 1);
      seen = 1'b0;
      repeat (3) begin
         step();
         seen |= out_valid;
      end
      chk("fl_sh_no_result", seen, 0);

      // flush of a held taken branch
      out_ready = 1'b0;
      drive(CLS_BRANCH, ALU_ADD, F3_BEQ, 32'd3, 32'd3, 20'h00004, 10'h010, 5'd0);
      step();
      in_valid = 1'b0;
      chk("beq_redir", redirect_valid, 1);
      chk("beq_pc", redirect_pc, 10'h014);
      step();
      chk("beq_no_repeat", redirect_valid, 0);
      chk("beq_held", out_valid, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("fl_br_valid", out_valid, 0);
      chk("fl_br_redir", redirect_valid, 0);
      chk("fl_br_ready", in_ready, 1);
      out_ready = 1'b1;

      // flush wins over a simultaneous accept
      drive(CLS_ALU, ALU_ADD, 3'd0, 32'd9, 32'd9, 20'd0, 10'd0, 5'd1);
      flush = 1'b1;
      #1 chk("fl_acc_ready", in_ready, 0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      #1 chk("fl_acc_valid", out_valid, 0);

      // reset in the middle of a shift
      drive(CLS_ALU, ALU_ADD, 3'd0, 32'd40, 32'd2, 20'd0, 10'd0, 5'd8);
      step();
      chk("pre_rst_add", out_result, 42);
      drive(CLS_ALU, ALU_SLL, 3'd0, 32'd1, 32'd31, 20'd0, 10'd0, 5'd9);
      step();
      in_valid = 1'b0;
      step();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_result", out_result, 0);
      chk("arst_rd", out_rd, 0);
      chk("arst_ready", in_ready, 0);
      #1 rst_n = 1'b1;
      step();
      chk("arst_ready_after", in_ready, 1);
      seen = 1'b0;
      repeat (9) begin
         step();
         seen |= out_valid;
      end
      chk("arst_shift_discarded", seen, 0);
      drive(CLS_ALU, ALU_ADD, 3'd0, 32'd2, 32'd3, 20'd0, 10'd0, 5'd10);
      step();
      in_valid = 1'b0;
      chk("post_arst_result", out_result, 5);
      chk("post_arst_rd", out_rd, 10);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
